mlt_dmem_ctrl: RTL and testbench

Data-memory bus controller sitting directly downstream of the multicycle processor top. It answers the processor's data-bus requests (MREQ/WRITE/SIZE/DAD/DDT) with a fixed-latency, wait-stated access to an internal word-organised RAM. It acknowledges each transfer on ACKD_n and handles byte/halfword lane selection and alignment checking.

---
 rtl/mlt_dmem_ctrl.sv | 133 +++++++++++++
 tb/tb_mlt_dmem_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mlt_dmem_ctrl.sv
// Data-memory bus controller: fixed-latency, wait-stated access to an internal word RAM
// with big-endian byte/halfword lane handling, alignment/range checking and a one-cycle ACKD_n.
module mlt_dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    input  logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        ACKD_n,
    output logic        ERR
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t        state, state_nxt;
    logic          capture;
    logic [3:0]    cnt;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic          req_write;
    logic [31:0]   req_data;
    logic          req_err;
    logic          in_err;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   rdata_fmt;
    logic [31:0]   wlane;
    logic [3:0]    be;
    logic [1:0]    off;
    logic [4:0]    bsh;

    function automatic logic addr_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00)
               || ((a >> (AW + 2)) != 32'd0);
    endfunction

    assign in_err = addr_err(SIZE, DAD);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (MREQ) begin
                    capture   = 1'b1;
                    state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ACKD_n/ERR are flops fed from the next state so they carry no input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            req_addr  <= 32'd0;
            req_size  <= 2'd0;
            req_write <= 1'b0;
            req_data  <= 32'd0;
            req_err   <= 1'b0;
            ACKD_n    <= 1'b1;
            ERR       <= 1'b0;
        end else begin
            state  <= state_nxt;
            ACKD_n <= (state_nxt != S_ACK);
            ERR    <= (state_nxt == S_ACK) && (capture ? in_err : req_err);
            if (capture) begin
                req_addr  <= DAD;
                req_size  <= SIZE;
                req_write <= WRITE;
                req_data  <= DDT;
                req_err   <= in_err;
                cnt       <= WAIT_LOAD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign idx     = req_addr[AW+1:2];
    assign rd_word = mem[idx];
    assign off     = req_addr[1:0];
    assign bsh     = {~off, 3'b000};

    // Big-endian lanes: offset 0 is bits [31:24]; be[b] enables bits [8b+7:8b].
    always_comb begin
        be        = 4'b0000;
        wlane     = 32'd0;
        rdata_fmt = 32'd0;
        case (req_size)
            2'b00: begin
                be        = 4'b1111;
                wlane     = req_data;
                rdata_fmt = rd_word;
            end
            2'b01: begin
                be        = off[1] ? 4'b0011 : 4'b1100;
                wlane     = {2{req_data[15:0]}};
                rdata_fmt = {16'h0, (off[1] ? rd_word[15:0] : rd_word[31:16])};
            end
            2'b10: begin
                be        = 4'b1000 >> off;
                wlane     = {4{req_data[7:0]}};
                rdata_fmt = {24'h0, rd_word[bsh +: 8]};
            end
            default: ;
        endcase
        if (req_err) rdata_fmt = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (state == S_ACK && req_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    assign DDT = (state == S_ACK && !req_write) ? rdata_fmt : 32'bz;

endmodule

// File: tb/tb_mlt_dmem_ctrl.sv
// Directed bench for mlt_dmem_ctrl: unit 0 built with two wait states, unit 1 with none.
module tb_mlt_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_req [2];
    logic        m_wr  [2];
    logic [1:0]  m_sz  [2];
    logic [31:0] m_ad  [2];
    logic [31:0] t_dat [2];
    logic        t_drv [2];
    wire  [31:0] bus0, bus1;
    logic        ack0, ack1, err0, err1;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign bus0 = t_drv[0] ? t_dat[0] : 32'bz;
    assign bus1 = t_drv[1] ? t_dat[1] : 32'bz;

    mlt_dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .MREQ(m_req[0]), .WRITE(m_wr[0]), .SIZE(m_sz[0]),
        .DAD(m_ad[0]), .DDT(bus0), .ACKD_n(ack0), .ERR(err0));

    mlt_dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .MREQ(m_req[1]), .WRITE(m_wr[1]), .SIZE(m_sz[1]),
        .DAD(m_ad[1]), .DDT(bus1), .ACKD_n(ack1), .ERR(err1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // An undriven bus reads as Z in four-state simulators and as 0 in two-state ones.
    function automatic logic released(input logic [31:0] v);
        return (v === 32'hz) || (v === 32'h0);
    endfunction

    function automatic logic [31:0] bus(input int u);
        return (u == 0) ? bus0 : bus1;
    endfunction

    function automatic logic ack(input int u);
        return (u == 0) ? ack0 : ack1;
    endfunction

    function automatic logic errv(input int u);
        return (u == 0) ? err0 : err1;
    endfunction

    task automatic wait_ack(input int u, output int n, output logic rel);
        n   = 0;
        rel = 1'b1;
        @(posedge clk);
        do begin
            @(negedge clk);
            n++;
            if (ack(u)) rel &= released(bus(u));
        end while (ack(u) !== 1'b0 && n < 40);
    endtask

    task automatic do_req(input int u, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic rel);
        @(negedge clk);
        m_req[u] = 1'b1; m_wr[u] = wr; m_sz[u] = sz; m_ad[u] = a;
        t_dat[u] = d; t_drv[u] = wr;
        wait_ack(u, lat, rel);
        rd = bus(u);
        er = errv(u);
        m_req[u] = 1'b0; t_drv[u] = 1'b0;
    endtask

    task automatic chk_idle(input int u, input string tag);
        @(negedge clk);
        chk({tag, "_ackhi"}, 32'(ack(u)), 32'd1);
        chk({tag, "_errlo"}, 32'(errv(u)), 32'd0);
        chk({tag, "_hiz"}, 32'(released(bus(u))), 32'd1);
    endtask

    // Checked load: data, error flag, latency and bus released while waiting.
    task automatic ld(input int u, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] exp, input logic exp_err, input string tag);
        logic [31:0] rd; logic er; int lat; logic rel;
        do_req(u, 1'b0, sz, a, 32'h0, rd, er, lat, rel);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
        chk({tag, "_lat"}, 32'(lat), (u == 0) ? 32'd3 : 32'd1);
        chk({tag, "_waithiz"}, 32'(rel), 32'd1);
    endtask

    task automatic st(input int u, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err, input string tag);
        logic [31:0] rd; logic er; int lat; logic rel;
        do_req(u, 1'b1, sz, a, d, rd, er, lat, rel);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
        chk({tag, "_lat"}, 32'(lat), (u == 0) ? 32'd3 : 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n; logic rel;
        for (int u = 0; u < 2; u++) begin
            m_req[u] = 1'b0; m_wr[u] = 1'b0; m_sz[u] = 2'b00;
            m_ad[u] = 32'h0; t_dat[u] = 32'h0; t_drv[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("reset_ackhi", 32'(ack0), 32'd1);
        chk("reset_errlo", 32'(err0), 32'd0);
        chk("reset_hiz", 32'(released(bus0)), 32'd1);
        rst = 1'b1;

        // Reset in the middle of a store's wait states must discard the store.
        st(0, 2'b00, 32'h10, 32'h01020304, 1'b0, "pre_rst_st");
        @(negedge clk);
        m_req[0] = 1'b1; m_wr[0] = 1'b1; m_sz[0] = 2'b00; m_ad[0] = 32'h10;
        t_dat[0] = 32'h99999999; t_drv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_req[0] = 1'b0; t_drv[0] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mid_ackhi", 32'(ack0), 32'd1);
        chk("rst_mid_hiz", 32'(released(bus0)), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_ackhi", 32'(ack0), 32'd1);
        end
        rst = 1'b1;
        ld(0, 2'b00, 32'h10, 32'h01020304, 1'b0, "rst_ld");

        st(0, 2'b00, 32'h40, 32'hDEADBEEF, 1'b0, "w_st");
        chk_idle(0, "w_st_after");
        ld(0, 2'b00, 32'h40, 32'hDEADBEEF, 1'b0, "w_ld");
        chk_idle(0, "w_ld_after");

        st(0, 2'b00, 32'h80, 32'h11223344, 1'b0, "lane_w");
        st(0, 2'b10, 32'h81, 32'h000000AA, 1'b0, "lane_b");
        ld(0, 2'b00, 32'h80, 32'h11AA3344, 1'b0, "lane_wr");
        ld(0, 2'b10, 32'h83, 32'h00000044, 1'b0, "lane_b3");
        ld(0, 2'b10, 32'h80, 32'h00000011, 1'b0, "lane_b0");
        ld(0, 2'b01, 32'h82, 32'h00003344, 1'b0, "lane_h2");
        ld(0, 2'b01, 32'h80, 32'h000011AA, 1'b0, "lane_h0");
        st(0, 2'b01, 32'h80, 32'h0000BEEF, 1'b0, "lane_hst");
        ld(0, 2'b00, 32'h80, 32'hBEEF3344, 1'b0, "lane_hrd");

        st(0, 2'b00, 32'h0, 32'h0BADF00D, 1'b0, "e_pre");
        ld(0, 2'b01, 32'h41, 32'h0, 1'b1, "e_hmis");
        st(0, 2'b00, 32'h42, 32'h55555555, 1'b1, "e_wmis");
        ld(0, 2'b00, 32'h40, 32'hDEADBEEF, 1'b0, "e_wmis_chk");
        ld(0, 2'b11, 32'h40, 32'h0, 1'b1, "e_sz3");
        st(0, 2'b11, 32'h40, 32'h66666666, 1'b1, "e_sz3st");
        ld(0, 2'b00, 32'h40, 32'hDEADBEEF, 1'b0, "e_sz3_chk");
        st(0, 2'b00, 32'h1000, 32'h77777777, 1'b1, "e_range");
        ld(0, 2'b00, 32'h1000, 32'h0, 1'b1, "e_range_ld");
        ld(0, 2'b00, 32'h0, 32'h0BADF00D, 1'b0, "e_range_chk");

        // Back-to-back: MREQ held high, request switched to a load at the first ACK.
        @(negedge clk);
        m_req[0] = 1'b1; m_wr[0] = 1'b1; m_sz[0] = 2'b00; m_ad[0] = 32'hC0;
        t_dat[0] = 32'hCAFEF00D; t_drv[0] = 1'b1;
        wait_ack(0, n, rel);
        chk("b2b_lat1", 32'(n), 32'd3);
        chk("b2b_err1", 32'(err0), 32'd0);
        m_wr[0] = 1'b0; t_drv[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack0 !== 1'b0 && n < 40);
        chk("b2b_gap", 32'(n), 32'd4);
        chk("b2b_data", bus0, 32'hCAFEF00D);
        chk("b2b_err2", 32'(err0), 32'd0);
        m_req[0] = 1'b0;
        chk_idle(0, "b2b_after");

        st(1, 2'b00, 32'h0, 32'h5A5AA5A5, 1'b0, "w0_st");
        ld(1, 2'b00, 32'h0, 32'h5A5AA5A5, 1'b0, "w0_ld");
        ld(1, 2'b10, 32'h2, 32'h000000A5, 1'b0, "w0_ldb");
        chk_idle(1, "w0_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
